// File: rtl/addsub_pkg.sv
// ============================================================================
// Module  : addsub_pkg
// Brief   : Shared types and constants for the nibble-serial add/sub sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : addsub_pkg

`default_nettype wire

// File: rtl/four_bit_adder.sv
// ============================================================================
// Module  : four_bit_adder
// Brief   : Combinational 4-bit adder slice exposing the carry into bit 3
// Revision: 1.0
// ============================================================================
`default_nettype none

module four_bit_adder
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                carry_o,
    output logic                c3_o
);

    logic [3:0] w_low;
    logic [1:0] w_top;

    // Split at bit 3 so the carry into the sign bit is visible for overflow.
    assign w_low   = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, c_in};
    assign w_top   = {1'b0, a_i[3]} + {1'b0, b_i[3]} + {1'b0, w_low[3]};
    assign sum_o   = {w_top[0], w_low[2:0]};
    assign carry_o = w_top[1];
    assign c3_o    = w_low[3];

endmodule : four_bit_adder

`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
// ============================================================================
// Module  : addsub_seq_ctrl
// Brief   : Nibble-serial two's-complement add/subtract around one 4-bit slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         start_i,
    input  logic                         sub_i,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a_i,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NIBBLE_W*NIBBLES-1:0]  result_o,
    output logic                         carry_o,
    output logic                         overflow_o
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    state_t             r_state_q,  w_state_d;
    logic [WIDTH-1:0]   r_a_q,      w_a_d;
    logic [WIDTH-1:0]   r_b_q,      w_b_d;
    logic               r_carry_q,  w_carry_d;
    logic [IDX_W-1:0]   r_idx_q,    w_idx_d;
    logic [WIDTH-1:0]   r_result_q, w_result_d;
    logic               r_cout_q,   w_cout_d;
    logic               r_ovf_q,    w_ovf_d;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic                w_slice_cout;
    logic                w_slice_c3;

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx_q == IDX_W'(k)) begin
                w_a_nib = r_a_q[k*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    four_bit_adder u_slice (
        .a_i     (w_a_nib),
        .b_i     (w_b_nib),
        .c_in    (r_carry_q),
        .sum_o   (w_slice_sum),
        .carry_o (w_slice_cout),
        .c3_o    (w_slice_c3)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_carry_d  = r_carry_q;
        w_idx_d    = r_idx_q;
        w_result_d = r_result_q;
        w_cout_d   = r_cout_q;
        w_ovf_d    = r_ovf_q;

        case (r_state_q)
            IDLE: begin
                if (start_i) begin
                    // Subtract is A + ~B + 1: invert B here, the +1 rides in the carry.
                    w_state_d = RUN;
                    w_a_d     = a_i;
                    w_b_d     = sub_i ? ~b_i : b_i;
                    w_carry_d = sub_i;
                    w_idx_d   = '0;
                end
            end
            RUN: begin
                w_carry_d = w_slice_cout;
                for (int k = 0; k < NIBBLES; k++) begin
                    if (r_idx_q == IDX_W'(k)) begin
                        w_result_d[k*NIBBLE_W +: NIBBLE_W] = w_slice_sum;
                    end
                end
                if (r_idx_q == c_last_idx) begin
                    w_cout_d  = w_slice_cout;
                    w_ovf_d   = w_slice_cout ^ w_slice_c3;
                    w_state_d = DONE;
                end else begin
                    w_idx_d = r_idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state_q  <= IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_carry_q  <= 1'b0;
            r_idx_q    <= '0;
            r_result_q <= '0;
            r_cout_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_carry_q  <= w_carry_d;
            r_idx_q    <= w_idx_d;
            r_result_q <= w_result_d;
            r_cout_q   <= w_cout_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    assign busy_o     = (r_state_q != IDLE);
    assign done_o     = (r_state_q == DONE);
    assign result_o   = r_result_q;
    assign carry_o    = r_cout_q;
    assign overflow_o = r_ovf_q;

endmodule : addsub_seq_ctrl

`default_nettype wire
